// File: rtl/simple_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : simple_bus_arbiter
// Description : Round-robin sequencer sharing one command bus between N
//               requesters: issue, wait for done/timeout, then bus-reset.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_bus_arbiter #(
    parameter int N          = 4,
    parameter int TIMEOUT    = 32,
    parameter int CLR_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [4*N-1:0] req_cmd,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic           err_to,
    output logic           busy,
    output logic           bus_en,
    output logic [3:0]     bus_cmd,
    output logic           bus_rst,
    input  logic           bus_done
);

    localparam int C_IDX_W = $clog2(N);
    localparam int C_TMR_W = $clog2(TIMEOUT);
    localparam int C_CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(N - 1);
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT - 1);
    localparam logic [C_CLR_W-1:0] C_CLR_LOAD = C_CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [C_IDX_W-1:0]   ptr_q,     ptr_d;
    logic [C_IDX_W-1:0]   owner_q,   owner_d;
    logic [C_TMR_W-1:0]   timer_q,   timer_d;
    logic [C_CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [N-1:0]         grant_q,   grant_d;
    logic [N-1:0]         ack_q,     ack_d;
    logic                 err_to_q,  err_to_d;
    logic                 bus_en_q,  bus_en_d;
    logic [3:0]           bus_cmd_q, bus_cmd_d;
    logic                 bus_rst_q, bus_rst_d;
    logic                 busy_q,    busy_d;

    logic                 sel_found;
    logic [C_IDX_W-1:0]   sel_idx;
    logic [C_IDX_W-1:0]   cand;
    logic [C_IDX_W-1:0]   next_ptr;

    // Scan downward so the smallest offset from the pointer is written last and wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = C_IDX_W'((int'(ptr_q) + i) % N);
            if (req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign next_ptr = (owner_q == C_IDX_LAST) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        clr_cnt_d = clr_cnt_q;
        grant_d   = grant_q;
        ack_d     = '0;
        err_to_d  = 1'b0;
        bus_en_d  = 1'b0;
        bus_cmd_d = bus_cmd_q;
        bus_rst_d = bus_rst_q;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d          = S_ISSUE;
                    owner_d          = sel_idx;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    bus_cmd_d        = req_cmd[4*sel_idx +: 4];
                    bus_en_d         = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // Done is checked first so a coincident timeout still completes as success.
                if (bus_done || (timer_q == C_TMR_LAST)) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = C_CLR_LOAD;
                    bus_rst_d = 1'b1;
                    ptr_d     = next_ptr;
                    if (bus_done) begin
                        ack_d = grant_q;
                    end else begin
                        err_to_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == '0) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    bus_rst_d = 1'b0;
                    busy_d    = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            ptr_q     <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            clr_cnt_q <= C_CLR_LOAD;
            grant_q   <= '0;
            ack_q     <= '0;
            err_to_q  <= 1'b0;
            bus_en_q  <= 1'b0;
            bus_cmd_q <= '0;
            bus_rst_q <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            clr_cnt_q <= clr_cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_to_q  <= err_to_d;
            bus_en_q  <= bus_en_d;
            bus_cmd_q <= bus_cmd_d;
            bus_rst_q <= bus_rst_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign ack     = ack_q;
    assign err_to  = err_to_q;
    assign busy    = busy_q;
    assign bus_en  = bus_en_q;
    assign bus_cmd = bus_cmd_q;
    assign bus_rst = bus_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_simple_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_simple_bus_arbiter
// Description : Scoreboard bench for simple_bus_arbiter with a bus responder
//               and a transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_bus_arbiter;

    localparam int N          = 4;
    localparam int TIMEOUT    = 32;
    localparam int CLR_CYCLES = 2;
    localparam int NEVER      = 999;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [4*N-1:0] req_cmd;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           err_to;
    logic           busy;
    logic           bus_en;
    logic [3:0]     bus_cmd;
    logic           bus_rst;
    logic           bus_done;

    simple_bus_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_cmd  (req_cmd),
        .grant    (grant),
        .ack      (ack),
        .err_to   (err_to),
        .busy     (busy),
        .bus_en   (bus_en),
        .bus_cmd  (bus_cmd),
        .bus_rst  (bus_rst),
        .bus_done (bus_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [3:0] cmd;
        bit         ok;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   dly_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Requesters: each holds req while it has unserved commands in its list.
    logic [3:0] list [N][64];
    int         tot      [N] = '{default: 0};
    int         done_cnt [N] = '{default: 0};

    initial begin : driver
        req     = '0;
        req_cmd = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!rst && req[i] && (ack[i] || (err_to && grant[i])))
                    done_cnt[i]++;
                req[i]            = (done_cnt[i] < tot[i]);
                req_cmd[4*i +: 4] = list[i][done_cnt[i] % 64];
            end
        end
    end

    // Bus responder: raises sticky done a programmed number of WAIT cycles after bus_en.
    logic stale_tog = 1'b0;
    logic bm_stale_prev;
    bit   bm_armed;
    int   bm_cnt;
    int   bm_d;

    initial begin : bus_model
        bus_done      = 1'b0;
        bm_armed      = 1'b0;
        bm_cnt        = 0;
        bm_stale_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus_done = 1'b0;
                bm_armed = 1'b0;
            end else begin
                if (bus_rst) bus_done = 1'b0;
                if (stale_tog != bm_stale_prev) bus_done = 1'b1;
                if (bus_en) begin
                    bm_d = NEVER;
                    if (dly_q.size() > 0) bm_d = dly_q.pop_front();
                    bm_armed = (bm_d < TIMEOUT);
                    bm_cnt   = bm_d;
                end else if (bm_armed) begin
                    if (bm_cnt == 0) begin
                        bus_done = 1'b1;
                        bm_armed = 1'b0;
                    end else begin
                        bm_cnt--;
                    end
                end
            end
            bm_stale_prev = stale_tog;
        end
    end

    exp_t cur;
    bit   in_flight = 1'b0;
    int   cyc       = 0;
    int   en_cyc    = 0;
    int   last_en   = -100;
    int   rst_len   = 0;
    bit   prev_en   = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_flight = 1'b0;
                rst_len   = 0;
                prev_en   = 1'b0;
            end else begin
                if (bus_en) begin
                    chk(!prev_en, "bus_en_width", 2, 1);
                    chk(cyc - last_en >= 3 + CLR_CYCLES, "bus_en_spacing", cyc - last_en, 3 + CLR_CYCLES);
                    last_en = cyc;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_bus_en", int'(grant), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk(grant == oh(cur.owner), "grant_at_issue", int'(grant), int'(oh(cur.owner)));
                        chk(bus_cmd == cur.cmd, "bus_cmd", int'(bus_cmd), int'(cur.cmd));
                        in_flight = 1'b1;
                        en_cyc    = cyc;
                    end
                end
                if (ack != '0 || err_to) begin
                    if (!in_flight) begin
                        chk(1'b0, "spurious_completion", int'(ack) + (err_to ? 100 : 0), 0);
                    end else begin
                        chk(ack == (cur.ok ? oh(cur.owner) : '0), "ack", int'(ack), cur.ok ? int'(oh(cur.owner)) : 0);
                        chk(err_to == !cur.ok, "err_to", int'(err_to), int'(!cur.ok));
                        chk(grant == oh(cur.owner), "grant_at_done", int'(grant), int'(oh(cur.owner)));
                        chk(cyc - en_cyc == cur.lat, "completion_latency", cyc - en_cyc, cur.lat);
                        in_flight = 1'b0;
                    end
                end
                if (bus_rst) begin
                    rst_len++;
                end else if (rst_len > 0) begin
                    chk(rst_len == CLR_CYCLES, "bus_rst_len", rst_len, CLR_CYCLES);
                    chk(grant == '0 && !busy, "idle_after_clear", int'(grant) + (busy ? 100 : 0), 0);
                    rst_len = 0;
                end
                prev_en = bus_en;
            end
        end
    end

    int         model_ptr = 0;
    int         s_cnt [N];
    logic [3:0] s_cmd [N][4];
    int         s_dly [N][4];
    bit         s_stale;

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 3000 && !idle; k++) begin
            @(posedge clk); #1;
            idle = !busy && !in_flight && (exp_q.size() == 0);
            for (int i = 0; i < N; i++)
                if (done_cnt[i] != tot[i]) idle = 1'b0;
        end
        chk(idle, "wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic clear_stage();
        for (int r = 0; r < N; r++) s_cnt[r] = 0;
        s_stale = 1'b0;
    endtask

    // Reference: serve pending requesters in upward order from the pointer, one command each visit.
    task automatic issue();
        int   rem [N];
        int   pos [N];
        int   p;
        int   sel;
        int   left;
        exp_t e;
        wait_idle();
        left = 0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < s_cnt[r]; k++) list[r][(tot[r] + k) % 64] = s_cmd[r][k];
            rem[r] = s_cnt[r];
            pos[r] = 0;
            left  += s_cnt[r];
        end
        p = model_ptr;
        while (left > 0) begin
            sel = p;
            for (int off = N - 1; off >= 0; off--)
                if (rem[(p + off) % N] > 0) sel = (p + off) % N;
            e.owner = sel;
            e.cmd   = s_cmd[sel][pos[sel]];
            if (s_stale) begin
                e.ok  = 1'b1;
                e.lat = 2;
                dly_q.push_back(NEVER);
            end else begin
                e.ok  = (s_dly[sel][pos[sel]] < TIMEOUT);
                e.lat = e.ok ? s_dly[sel][pos[sel]] + 2 : TIMEOUT + 1;
                dly_q.push_back(s_dly[sel][pos[sel]]);
            end
            exp_q.push_back(e);
            rem[sel]--;
            pos[sel]++;
            left--;
            p = (sel + 1) % N;
        end
        model_ptr = p;
        for (int r = 0; r < N; r++) tot[r] += s_cnt[r];
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got %0d checks expected completion", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk(grant == '0,  "rst_grant",   int'(grant),   0);
        chk(ack == '0,    "rst_ack",     int'(ack),     0);
        chk(!err_to,      "rst_err_to",  int'(err_to),  0);
        chk(!bus_en,      "rst_bus_en",  int'(bus_en),  0);
        chk(bus_cmd == 0, "rst_bus_cmd", int'(bus_cmd), 0);
        chk(busy,         "rst_busy",    int'(busy),    1);
        chk(bus_rst,      "rst_bus_rst", int'(bus_rst), 1);
        rst = 1'b0;

        clear_stage(); s_cnt[0] = 1; s_cmd[0][0] = 4'hA; s_dly[0][0] = 16;        issue();
        clear_stage(); s_cnt[2] = 1; s_cmd[2][0] = 4'h5; s_dly[2][0] = NEVER;     issue();
        clear_stage();
        for (int r = 0; r < N; r++) begin
            s_cnt[r] = 1; s_cmd[r][0] = 4'(r + 8); s_dly[r][0] = r + 3;
        end
        issue();
        clear_stage(); s_cnt[1] = 1; s_cmd[1][0] = 4'h7; s_dly[1][0] = TIMEOUT - 1; issue();

        wait_idle();
        stale_tog = ~stale_tog;
        repeat (4) @(posedge clk);
        #1;
        chk(!busy && !bus_en, "stale_done_in_idle", int'(busy) + int'(bus_en), 0);
        clear_stage(); s_cnt[1] = 1; s_cmd[1][0] = 4'hC; s_stale = 1'b1; issue();

        clear_stage(); s_cnt[2] = 1; s_cmd[2][0] = 4'h3; s_dly[2][0] = NEVER; issue();
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus_en;
        end
        chk(seen, "rst_test_bus_en", int'(seen), 1);
        repeat (6) @(posedge clk);
        #1;
        rst    = 1'b1;
        tot[2] = done_cnt[2];
        @(posedge clk); #1;
        rst = 1'b0;
        chk(grant == '0, "midrst_grant",   int'(grant),   0);
        chk(ack == '0,   "midrst_ack",     int'(ack),     0);
        chk(!err_to,     "midrst_err_to",  int'(err_to),  0);
        chk(bus_rst,     "midrst_bus_rst", int'(bus_rst), 1);
        model_ptr = 0;

        clear_stage();
        s_cnt[0] = 2; s_cmd[0][0] = 4'h1; s_cmd[0][1] = 4'h1;
        s_cnt[1] = 1; s_cmd[1][0] = 4'h2;
        s_cnt[2] = 1; s_cmd[2][0] = 4'h3;
        s_cnt[3] = 1; s_cmd[3][0] = 4'h4;
        for (int r = 0; r < N; r++) begin
            s_dly[r][0] = 2 + r; s_dly[r][1] = 5;
        end
        issue();

        repeat (15) begin
            int mask;
            clear_stage();
            mask = $urandom_range(1, (1 << N) - 1);
            for (int r = 0; r < N; r++) begin
                if (mask[r]) begin
                    s_cnt[r] = $urandom_range(1, 3);
                    for (int k = 0; k < 4; k++) begin
                        s_cmd[r][k] = 4'($urandom_range(0, 15));
                        case ($urandom_range(0, 9))
                            0:       s_dly[r][k] = TIMEOUT - 1;
                            1:       s_dly[r][k] = NEVER;
                            2:       s_dly[r][k] = TIMEOUT;
                            default: s_dly[r][k] = $urandom_range(0, 20);
                        endcase
                    end
                end
            end
            issue();
        end

        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
